// File: rtl/nasti_mux_n_if.sv
// rtl/nasti_mux_n_if.sv - N-lane NASTI channel bundle with master/slave modports
interface nasti_channel #(
  parameter int N_LANE     = 1,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  logic [N_LANE-1:0][ID_WIDTH-1:0]     aw_id;
  logic [N_LANE-1:0][ADDR_WIDTH-1:0]   aw_addr;
  logic [N_LANE-1:0][7:0]              aw_len;
  logic [N_LANE-1:0][2:0]              aw_size;
  logic [N_LANE-1:0][1:0]              aw_burst;
  logic [N_LANE-1:0][USER_WIDTH-1:0]   aw_user;
  logic [N_LANE-1:0]                   aw_valid;
  logic [N_LANE-1:0]                   aw_ready;

  logic [N_LANE-1:0][DATA_WIDTH-1:0]   w_data;
  logic [N_LANE-1:0][DATA_WIDTH/8-1:0] w_strb;
  logic [N_LANE-1:0]                   w_last;
  logic [N_LANE-1:0][USER_WIDTH-1:0]   w_user;
  logic [N_LANE-1:0]                   w_valid;
  logic [N_LANE-1:0]                   w_ready;

  logic [N_LANE-1:0][ID_WIDTH-1:0]     b_id;
  logic [N_LANE-1:0][1:0]              b_resp;
  logic [N_LANE-1:0][USER_WIDTH-1:0]   b_user;
  logic [N_LANE-1:0]                   b_valid;
  logic [N_LANE-1:0]                   b_ready;

  logic [N_LANE-1:0][ID_WIDTH-1:0]     ar_id;
  logic [N_LANE-1:0][ADDR_WIDTH-1:0]   ar_addr;
  logic [N_LANE-1:0][7:0]              ar_len;
  logic [N_LANE-1:0][2:0]              ar_size;
  logic [N_LANE-1:0][1:0]              ar_burst;
  logic [N_LANE-1:0][USER_WIDTH-1:0]   ar_user;
  logic [N_LANE-1:0]                   ar_valid;
  logic [N_LANE-1:0]                   ar_ready;

  logic [N_LANE-1:0][ID_WIDTH-1:0]     r_id;
  logic [N_LANE-1:0][DATA_WIDTH-1:0]   r_data;
  logic [N_LANE-1:0][1:0]              r_resp;
  logic [N_LANE-1:0]                   r_last;
  logic [N_LANE-1:0][USER_WIDTH-1:0]   r_user;
  logic [N_LANE-1:0]                   r_valid;
  logic [N_LANE-1:0]                   r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/nasti_mux_n.sv
// rtl/nasti_mux_n.sv - N-to-1 NASTI multiplexer with ID-routed responses
// Round-robin AW/AR arbitration, W locked to the granted AW, B/R routed through outstanding tables.
module nasti_mux_n #(
  parameter int N_PORT     = 4,
  parameter int W_MAX      = 4,
  parameter int R_MAX      = 4,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int LITE_MODE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  nasti_channel.slave            master,
  nasti_channel.master           slave,
  output logic [$clog2(W_MAX):0] w_outstanding,
  output logic [$clog2(R_MAX):0] r_outstanding,
  output logic                   unmatched
);
  localparam int PW  = $clog2(N_PORT);
  localparam int WI  = $clog2(W_MAX);
  localparam int RI  = $clog2(R_MAX);
  localparam int WCW = WI + 1;
  localparam int RCW = RI + 1;

  typedef logic [PW-1:0]       port_t;
  typedef logic [ID_WIDTH-1:0] id_t;
  typedef enum logic {W_IDLE, W_LOCKED} wstate_t;

  function automatic port_t rr_pick(input logic [N_PORT-1:0] req, input port_t ptr);
    port_t sel;
    logic  found;
    int    idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_PORT; k++) begin
      idx = (int'(ptr) + k) % N_PORT;
      if (!found && req[idx]) begin
        sel   = port_t'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic port_t next_port(input port_t p);
    return (int'(p) == N_PORT - 1) ? '0 : p + 1'b1;
  endfunction

  wstate_t           w_state_q, w_state_d;
  port_t             locked_port_q, locked_port_d;
  logic              lock_q, w_hs;

  logic [W_MAX-1:0]  wt_vld_q, wt_vld_d;
  id_t               wt_id_q   [W_MAX];
  id_t               wt_id_d   [W_MAX];
  port_t             wt_port_q [W_MAX];
  port_t             wt_port_d [W_MAX];
  logic [R_MAX-1:0]  rt_vld_q, rt_vld_d;
  id_t               rt_id_q   [R_MAX];
  id_t               rt_id_d   [R_MAX];
  port_t             rt_port_q [R_MAX];
  port_t             rt_port_d [R_MAX];

  logic [N_PORT-1:0] aw_req, ar_req;
  port_t             aw_sel, ar_sel, aw_ptr_q, aw_ptr_d, ar_ptr_q, ar_ptr_d;
  port_t             aw_hold_port_q, aw_hold_port_d, ar_hold_port_q, ar_hold_port_d;
  logic              aw_hold_q, aw_hold_d, ar_hold_q, ar_hold_d;
  logic              aw_gnt, aw_hs, ar_gnt, ar_hs;
  logic [WI-1:0]     wt_free_idx, b_idx;
  logic [RI-1:0]     rt_free_idx, r_idx;
  logic              b_hit, b_hs, r_hit, r_hs, r_free;
  port_t             b_port, r_port;
  logic [WCW-1:0]    w_cnt_q, w_cnt_d;
  logic [RCW-1:0]    r_cnt_q, r_cnt_d;
  logic              unmatched_q, unmatched_d;

  assign lock_q = (w_state_q == W_LOCKED);

  // Eligibility and full are taken from registered tables so a same-cycle free cannot admit a request.
  always_comb begin
    aw_req = '0;
    ar_req = '0;
    for (int i = 0; i < N_PORT; i++) begin
      aw_req[i] = master.aw_valid[i];
      ar_req[i] = master.ar_valid[i];
      for (int k = 0; k < W_MAX; k++)
        if (wt_vld_q[k] && wt_id_q[k] == master.aw_id[i] && wt_port_q[k] != port_t'(i))
          aw_req[i] = 1'b0;
      for (int k = 0; k < R_MAX; k++)
        if (rt_vld_q[k] && rt_id_q[k] == master.ar_id[i] && rt_port_q[k] != port_t'(i))
          ar_req[i] = 1'b0;
    end
    aw_sel = aw_hold_q ? aw_hold_port_q : rr_pick(aw_req, aw_ptr_q);
    ar_sel = ar_hold_q ? ar_hold_port_q : rr_pick(ar_req, ar_ptr_q);
    aw_gnt = !lock_q && !(&wt_vld_q) && aw_req[aw_sel];
    ar_gnt = !(&rt_vld_q) && ar_req[ar_sel];
    aw_hs  = aw_gnt && slave.aw_ready[0];
    ar_hs  = ar_gnt && slave.ar_ready[0];
  end

  always_comb begin
    slave.aw_valid[0] = aw_gnt;
    slave.aw_id[0]    = master.aw_id[aw_sel];
    slave.aw_addr[0]  = master.aw_addr[aw_sel];
    slave.aw_len[0]   = master.aw_len[aw_sel];
    slave.aw_size[0]  = master.aw_size[aw_sel];
    slave.aw_burst[0] = master.aw_burst[aw_sel];
    slave.aw_user[0]  = master.aw_user[aw_sel];
    master.aw_ready   = '0;
    master.aw_ready[aw_sel] = aw_hs;
    slave.ar_valid[0] = ar_gnt;
    slave.ar_id[0]    = master.ar_id[ar_sel];
    slave.ar_addr[0]  = master.ar_addr[ar_sel];
    slave.ar_len[0]   = master.ar_len[ar_sel];
    slave.ar_size[0]  = master.ar_size[ar_sel];
    slave.ar_burst[0] = master.ar_burst[ar_sel];
    slave.ar_user[0]  = master.ar_user[ar_sel];
    master.ar_ready   = '0;
    master.ar_ready[ar_sel] = ar_hs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q     <= W_IDLE;
      locked_port_q <= '0;
    end else begin
      w_state_q     <= w_state_d;
      locked_port_q <= locked_port_d;
    end
  end

  always_comb begin
    w_state_d     = w_state_q;
    locked_port_d = locked_port_q;
    case (w_state_q)
      W_IDLE:
        if (aw_hs) begin
          w_state_d     = W_LOCKED;
          locked_port_d = aw_sel;
        end
      W_LOCKED:
        if (w_hs && (LITE_MODE != 0 || slave.w_last[0]))
          w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    slave.w_data[0]  = master.w_data[locked_port_q];
    slave.w_strb[0]  = master.w_strb[locked_port_q];
    slave.w_last[0]  = master.w_last[locked_port_q];
    slave.w_user[0]  = master.w_user[locked_port_q];
    slave.w_valid[0] = lock_q && master.w_valid[locked_port_q];
    w_hs             = slave.w_valid[0] && slave.w_ready[0];
    master.w_ready   = '0;
    master.w_ready[locked_port_q] = w_hs;
  end

  // Lowest-index match on responses; a miss is drained with ready held high.
  always_comb begin
    b_hit = 1'b0;
    b_idx = '0;
    for (int k = W_MAX - 1; k >= 0; k--)
      if (wt_vld_q[k] && wt_id_q[k] == slave.b_id[0]) begin
        b_hit = 1'b1;
        b_idx = WI'(k);
      end
    b_port = wt_port_q[b_idx];
    for (int i = 0; i < N_PORT; i++) begin
      master.b_id[i]    = slave.b_id[0];
      master.b_resp[i]  = slave.b_resp[0];
      master.b_user[i]  = slave.b_user[0];
      master.b_valid[i] = slave.b_valid[0] && b_hit && b_port == port_t'(i);
    end
    slave.b_ready[0] = b_hit ? master.b_ready[b_port] : 1'b1;
    b_hs = slave.b_valid[0] && slave.b_ready[0];
  end

  always_comb begin
    r_hit = 1'b0;
    r_idx = '0;
    for (int k = R_MAX - 1; k >= 0; k--)
      if (rt_vld_q[k] && rt_id_q[k] == slave.r_id[0]) begin
        r_hit = 1'b1;
        r_idx = RI'(k);
      end
    r_port = rt_port_q[r_idx];
    for (int i = 0; i < N_PORT; i++) begin
      master.r_id[i]    = slave.r_id[0];
      master.r_data[i]  = slave.r_data[0];
      master.r_resp[i]  = slave.r_resp[0];
      master.r_last[i]  = slave.r_last[0];
      master.r_user[i]  = slave.r_user[0];
      master.r_valid[i] = slave.r_valid[0] && r_hit && r_port == port_t'(i);
    end
    slave.r_ready[0] = r_hit ? master.r_ready[r_port] : 1'b1;
    r_hs   = slave.r_valid[0] && slave.r_ready[0];
    r_free = r_hs && r_hit && slave.r_last[0];
  end

  always_comb begin
    wt_free_idx = '0;
    for (int k = W_MAX - 1; k >= 0; k--)
      if (!wt_vld_q[k]) wt_free_idx = WI'(k);
    rt_free_idx = '0;
    for (int k = R_MAX - 1; k >= 0; k--)
      if (!rt_vld_q[k]) rt_free_idx = RI'(k);

    wt_vld_d  = wt_vld_q;
    wt_id_d   = wt_id_q;
    wt_port_d = wt_port_q;
    if (b_hs && b_hit) wt_vld_d[b_idx] = 1'b0;
    if (aw_hs) begin
      wt_vld_d[wt_free_idx]  = 1'b1;
      wt_id_d[wt_free_idx]   = master.aw_id[aw_sel];
      wt_port_d[wt_free_idx] = aw_sel;
    end

    rt_vld_d  = rt_vld_q;
    rt_id_d   = rt_id_q;
    rt_port_d = rt_port_q;
    if (r_free) rt_vld_d[r_idx] = 1'b0;
    if (ar_hs) begin
      rt_vld_d[rt_free_idx]  = 1'b1;
      rt_id_d[rt_free_idx]   = master.ar_id[ar_sel];
      rt_port_d[rt_free_idx] = ar_sel;
    end

    aw_ptr_d       = aw_hs ? next_port(aw_sel) : aw_ptr_q;
    ar_ptr_d       = ar_hs ? next_port(ar_sel) : ar_ptr_q;
    aw_hold_d      = aw_gnt && !slave.aw_ready[0];
    ar_hold_d      = ar_gnt && !slave.ar_ready[0];
    aw_hold_port_d = aw_sel;
    ar_hold_port_d = ar_sel;

    w_cnt_d     = w_cnt_q + WCW'(aw_hs) - WCW'(b_hs && b_hit);
    r_cnt_d     = r_cnt_q + RCW'(ar_hs) - RCW'(r_free);
    unmatched_d = (b_hs && !b_hit) || (r_hs && !r_hit && slave.r_last[0]);
  end

  always_ff @(posedge clk) begin
    wt_id_q        <= wt_id_d;
    wt_port_q      <= wt_port_d;
    rt_id_q        <= rt_id_d;
    rt_port_q      <= rt_port_d;
    aw_hold_port_q <= aw_hold_port_d;
    ar_hold_port_q <= ar_hold_port_d;
    if (rst) begin
      wt_vld_q    <= '0;
      rt_vld_q    <= '0;
      aw_ptr_q    <= '0;
      ar_ptr_q    <= '0;
      aw_hold_q   <= 1'b0;
      ar_hold_q   <= 1'b0;
      w_cnt_q     <= '0;
      r_cnt_q     <= '0;
      unmatched_q <= 1'b0;
    end else begin
      wt_vld_q    <= wt_vld_d;
      rt_vld_q    <= rt_vld_d;
      aw_ptr_q    <= aw_ptr_d;
      ar_ptr_q    <= ar_ptr_d;
      aw_hold_q   <= aw_hold_d;
      ar_hold_q   <= ar_hold_d;
      w_cnt_q     <= w_cnt_d;
      r_cnt_q     <= r_cnt_d;
      unmatched_q <= unmatched_d;
    end
  end

  assign w_outstanding = w_cnt_q;
  assign r_outstanding = r_cnt_q;
  assign unmatched     = unmatched_q;
endmodule

// File: tb/tb_nasti_mux_n.sv
// tb/tb_nasti_mux_n.sv - directed self-checking bench for nasti_mux_n
module tb_nasti_mux_n;
  localparam int NP  = 4;
  localparam int IDW = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int UW  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] w_outstanding;
  logic [1:0] r_outstanding;
  logic       unmatched;
  int         n_vec = 0;
  int         n_err = 0;

  nasti_channel #(.N_LANE(NP), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();
  nasti_channel #(.N_LANE(1),  .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();

  nasti_mux_n #(
    .N_PORT(NP), .W_MAX(4), .R_MAX(2), .ID_WIDTH(IDW), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .LITE_MODE(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .master       (m_if.slave),
    .slave        (s_if.master),
    .w_outstanding(w_outstanding),
    .r_outstanding(r_outstanding),
    .unmatched    (unmatched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_all();
    m_if.aw_id = '0; m_if.aw_addr = '0; m_if.aw_len = '0; m_if.aw_size = '0;
    m_if.aw_burst = '0; m_if.aw_user = '0; m_if.aw_valid = '0;
    m_if.w_data = '0; m_if.w_strb = '0; m_if.w_last = '0; m_if.w_user = '0; m_if.w_valid = '0;
    m_if.b_ready = '1;
    m_if.ar_id = '0; m_if.ar_addr = '0; m_if.ar_len = '0; m_if.ar_size = '0;
    m_if.ar_burst = '0; m_if.ar_user = '0; m_if.ar_valid = '0;
    m_if.r_ready = '1;
    s_if.aw_ready = '1; s_if.w_ready = '1; s_if.ar_ready = '1;
    s_if.b_id = '0; s_if.b_resp = '0; s_if.b_user = '0; s_if.b_valid = '0;
    s_if.r_id = '0; s_if.r_data = '0; s_if.r_resp = '0; s_if.r_last = '0;
    s_if.r_user = '0; s_if.r_valid = '0;
  endtask

  initial begin
    init_all();
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("rst_w_valid", s_if.w_valid, 0);
    chk("rst_w_out", w_outstanding, 0);
    chk("rst_r_out", r_outstanding, 0);
    chk("rst_unmatched", unmatched, 0);
    chk("rst_b_valid", m_if.b_valid, 0);
    chk("rst_r_valid", m_if.r_valid, 0);

    // Write bursts from ports 0 and 2
    step();
    m_if.aw_id[0] = 2'd0; m_if.aw_addr[0] = 32'h1000; m_if.aw_len[0] = 8'd3; m_if.aw_valid[0] = 1'b1;
    m_if.aw_id[2] = 2'd1; m_if.aw_addr[2] = 32'h2000; m_if.aw_len[2] = 8'd3; m_if.aw_valid[2] = 1'b1;
    #1;
    chk("aw0_valid", s_if.aw_valid, 1);
    chk("aw0_addr", s_if.aw_addr, 32'h1000);
    chk("aw0_ready", m_if.aw_ready, 4'b0001);
    step();
    m_if.aw_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      m_if.w_valid[0] = 1'b1; m_if.w_data[0] = 32'hA0 + k; m_if.w_last[0] = (k == 3);
      m_if.w_valid[2] = 1'b1; m_if.w_data[2] = 32'hBAD;
      #1;
      chk("w0_data", s_if.w_data, 32'hA0 + k);
      chk("w0_ready", m_if.w_ready, 4'b0001);
      chk("aw_locked", s_if.aw_valid, 0);
    end
    chk("w_out1", w_outstanding, 1);
    step();
    m_if.w_valid[0] = 1'b0; m_if.w_valid[2] = 1'b0;
    #1;
    chk("aw2_ready", m_if.aw_ready, 4'b0100);
    chk("aw2_id", s_if.aw_id, 1);
    chk("w_idle", s_if.w_valid, 0);
    step();
    m_if.aw_valid[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      m_if.w_valid[2] = 1'b1; m_if.w_data[2] = 32'hC0 + k; m_if.w_last[2] = (k == 3);
      #1;
      chk("w2_data", s_if.w_data, 32'hC0 + k);
    end
    step();
    m_if.w_valid[2] = 1'b0; m_if.b_ready = 4'b0100;
    s_if.b_valid = 1'b1; s_if.b_id = 2'd0;
    #1;
    chk("w_out2", w_outstanding, 2);
    chk("b0_route", m_if.b_valid, 4'b0001);
    chk("b0_ready_lane", s_if.b_ready, 0);
    step();
    m_if.b_ready = 4'b1111;
    #1;
    chk("b0_ready", s_if.b_ready, 1);
    step();
    s_if.b_id = 2'd1;
    #1;
    chk("b1_route", m_if.b_valid, 4'b0100);
    chk("w_out_b0", w_outstanding, 1);
    step();
    s_if.b_valid = 1'b0;
    #1;
    chk("w_out_b1", w_outstanding, 0);

    // Same-ID reads from ports 1 and 3
    step();
    m_if.ar_id[1] = 2'd1; m_if.ar_addr[1] = 32'h3000; m_if.ar_valid[1] = 1'b1;
    m_if.ar_id[3] = 2'd1; m_if.ar_addr[3] = 32'h4000; m_if.ar_valid[3] = 1'b1;
    #1;
    chk("ar1_ready", m_if.ar_ready, 4'b0010);
    chk("ar1_addr", s_if.ar_addr, 32'h3000);
    step();
    m_if.ar_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      s_if.r_valid = 1'b1; s_if.r_id = 2'd1; s_if.r_data = 32'hD0 + k; s_if.r_last = (k == 3);
      #1;
      chk("r1_route", m_if.r_valid, 4'b0010);
      chk("ar3_stalled", s_if.ar_valid, 0);
      chk("r_out_peak", r_outstanding, 1);
    end
    step();
    s_if.r_valid = 1'b0; s_if.r_last = 1'b0;
    #1;
    chk("ar3_ready", m_if.ar_ready, 4'b1000);
    chk("r_out_freed", r_outstanding, 0);
    step();
    m_if.ar_valid[3] = 1'b0;
    s_if.r_valid = 1'b1; s_if.r_id = 2'd1; s_if.r_last = 1'b1;
    #1;
    chk("r3_route", m_if.r_valid, 4'b1000);
    chk("r_out_ar3", r_outstanding, 1);
    step();
    s_if.r_valid = 1'b0;
    #1;
    chk("r_out_ar3_done", r_outstanding, 0);

    // Read table full (R_MAX=2) with three requesters
    step();
    m_if.ar_id[0] = 2'd0; m_if.ar_valid[0] = 1'b1;
    m_if.ar_id[1] = 2'd1; m_if.ar_valid[1] = 1'b1;
    m_if.ar_id[2] = 2'd2; m_if.ar_valid[2] = 1'b1;
    #1;
    chk("full_ar0", m_if.ar_ready, 4'b0001);
    step();
    m_if.ar_valid[0] = 1'b0;
    #1;
    chk("full_ar1", m_if.ar_ready, 4'b0010);
    step();
    m_if.ar_valid[1] = 1'b0;
    #1;
    chk("full_stall", s_if.ar_valid, 0);
    chk("r_out_full", r_outstanding, 2);
    step();
    s_if.r_valid = 1'b1; s_if.r_id = 2'd0; s_if.r_last = 1'b1;
    #1;
    chk("full_r0_route", m_if.r_valid, 4'b0001);
    chk("full_same_cycle", s_if.ar_valid, 0);
    step();
    s_if.r_valid = 1'b0;
    #1;
    chk("full_ar2", m_if.ar_ready, 4'b0100);
    chk("r_out_after_free", r_outstanding, 1);
    step();
    m_if.ar_valid[2] = 1'b0;
    s_if.r_valid = 1'b1; s_if.r_id = 2'd1;
    #1;
    chk("full_r1_route", m_if.r_valid, 4'b0010);
    chk("r_out_refull", r_outstanding, 2);
    step();
    s_if.r_id = 2'd2;
    #1;
    chk("full_r2_route", m_if.r_valid, 4'b0100);
    step();
    s_if.r_valid = 1'b0; s_if.r_last = 1'b0;
    #1;
    chk("r_out_drained", r_outstanding, 0);

    // Unmatched B response
    step();
    s_if.b_valid = 1'b1; s_if.b_id = 2'd3; m_if.b_ready = 4'b0000;
    #1;
    chk("um_b_valid", m_if.b_valid, 0);
    chk("um_b_ready", s_if.b_ready, 1);
    chk("um_pre", unmatched, 0);
    step();
    s_if.b_valid = 1'b0; m_if.b_ready = 4'b1111;
    #1;
    chk("um_pulse", unmatched, 1);
    chk("um_w_out", w_outstanding, 0);
    chk("um_r_out", r_outstanding, 0);
    step();
    #1;
    chk("um_clear", unmatched, 0);

    // Round-robin rotation with all ports requesting continuously
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) m_if.ar_id[i] = IDW'(i);
    m_if.ar_valid = 4'b1111;
    #1;
    chk("rot_0", m_if.ar_ready, 4'b0001);
    for (int k = 1; k < 5; k++) begin
      step();
      s_if.r_valid = 1'b1; s_if.r_id = IDW'(k - 1); s_if.r_last = 1'b1;
      #1;
      chk("rot_grant", m_if.ar_ready, 64'(1 << (k % 4)));
      chk("rot_r_route", m_if.r_valid, 64'(1 << (k - 1)));
      chk("rot_r_out", r_outstanding, 1);
    end
    step();
    m_if.ar_valid = 4'b0000; s_if.r_id = 2'd0;
    #1;
    chk("rot_r_last", m_if.r_valid, 4'b0001);
    step();
    s_if.r_valid = 1'b0; s_if.r_last = 1'b0;
    #1;
    chk("rot_r_out0", r_outstanding, 0);

    // Reset in the middle of a write burst
    step();
    m_if.aw_id[1] = 2'd2; m_if.aw_len[1] = 8'd3; m_if.aw_valid[1] = 1'b1;
    #1;
    chk("mid_aw1", m_if.aw_ready, 4'b0010);
    step();
    m_if.aw_valid[1] = 1'b0;
    m_if.w_valid[1] = 1'b1; m_if.w_data[1] = 32'hE0; m_if.w_last[1] = 1'b0;
    #1;
    chk("mid_w_valid", s_if.w_valid, 1);
    chk("mid_w_out", w_outstanding, 1);
    step();
    m_if.w_data[1] = 32'hE1;
    step();
    rst = 1'b1; m_if.w_data[1] = 32'hE2;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_w_valid", s_if.w_valid, 0);
    chk("mid_rst_w_ready", m_if.w_ready, 0);
    chk("mid_rst_w_out", w_outstanding, 0);
    chk("mid_rst_r_out", r_outstanding, 0);
    step();
    m_if.w_valid[1] = 1'b0;
    s_if.b_valid = 1'b1; s_if.b_id = 2'd2;
    #1;
    chk("mid_b_drop", m_if.b_valid, 0);
    chk("mid_b_ready", s_if.b_ready, 1);
    step();
    s_if.b_valid = 1'b0;
    #1;
    chk("mid_unmatched", unmatched, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
